mem_map_ctrl: RTL and testbench

- Parametrised memory-map controller between the CPU bus and the program ROM, data RAM and an I/O port bank.
- Decodes each request into the ROM, RAM, I/O or unmapped region. Drives external synchronous ROM/RAM macros with 1-cycle read latency.
- Owns NUM_PORTS output port registers and NUM_PORTS input ports behind 2-flop synchronisers.
- Uses a req/ready handshake with programmable I/O wait states and flags unmapped accesses.

---
 rtl/mem_map_ctrl_if.sv | 16 +
 rtl/mem_map_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_mem_map_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_map_ctrl_if.sv
// CPU-side request/ready bus of the memory-map controller.
interface mem_map_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              ready;
    logic              err;

    modport master (output req, we, address, data_in, input data_out, ready, err);
    modport slave  (input req, we, address, data_in, output data_out, ready, err);
endinterface

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: decodes CPU accesses onto ROM/RAM macros and an I/O port bank.
// Optional MEM_MAP_IO_READBACK_EN: I/O reads return the output register instead of port_in.
module mem_map_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int ROM_TOP   = 'h80,
    parameter int RAM_TOP   = 'hE0,
    parameter int IO_BASE   = 'hF0,
    parameter int NUM_PORTS = 16,
    parameter int IO_WAIT   = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    mem_map_ctrl_if.slave               bus,
    output logic [ADDR_W-1:0]           rom_addr,
    input  logic [DATA_W-1:0]           rom_data,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic                        ram_we,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_data,
    input  logic [NUM_PORTS*DATA_W-1:0] port_in,
    output logic [NUM_PORTS*DATA_W-1:0] port_out
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW = 4;
    localparam logic [ADDR_W:0] ROM_END = (ADDR_W+1)'(ROM_TOP);
    localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(RAM_TOP);
    localparam logic [ADDR_W:0] IO_BEG  = (ADDR_W+1)'(IO_BASE);
    localparam logic [ADDR_W:0] IO_END  = (ADDR_W+1)'(IO_BASE + NUM_PORTS);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_IO, S_DONE} state_e;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_IO, REG_UNM} region_e;

    // Compare one bit wider so IO_BASE+NUM_PORTS may equal 2^ADDR_W.
    function automatic region_e decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] aw;
        aw = {1'b0, a};
        if (aw < ROM_END) begin
            return REG_ROM;
        end else if (aw < RAM_END) begin
            return REG_RAM;
        end else if ((aw >= IO_BEG) && (aw < IO_END)) begin
            return REG_IO;
        end else begin
            return REG_UNM;
        end
    endfunction

    state_e            state_q, state_d;
    region_e           region_q, region_d, cur_region_s;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, cur_addr_s;
    logic              we_q, we_d, cur_we_s;
    logic [DATA_W-1:0] wdata_q, wdata_d, cur_wdata_s;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] mem_rdata_s, port_rd_s;
    logic [PW-1:0]     pidx_s;
    logic              io_fire_s;
    logic [DATA_W-1:0] sync1_d    [NUM_PORTS];
    logic [DATA_W-1:0] sync1_q    [NUM_PORTS];
    logic [DATA_W-1:0] sync2_q    [NUM_PORTS];
    logic [DATA_W-1:0] port_out_q [NUM_PORTS];
    logic [DATA_W-1:0] port_out_d [NUM_PORTS];

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
        assign sync1_d[k]                     = port_in[k*DATA_W +: DATA_W];
        assign port_out[k*DATA_W +: DATA_W]   = port_out_q[k];
    end

    // In IDLE the live request is the access being accepted; afterwards the latched copy.
    assign cur_addr_s   = (state_q == S_IDLE) ? bus.address : addr_q;
    assign cur_we_s     = (state_q == S_IDLE) ? bus.we      : we_q;
    assign cur_wdata_s  = (state_q == S_IDLE) ? bus.data_in : wdata_q;
    assign cur_region_s = decode(bus.address);
    assign pidx_s       = PW'(cur_addr_s & ADDR_W'(NUM_PORTS - 1));
    assign mem_rdata_s  = (region_q == REG_ROM) ? rom_data : ram_data;
`ifdef MEM_MAP_IO_READBACK_EN
    assign port_rd_s    = port_out_q[pidx_s];
`else
    assign port_rd_s    = sync2_q[pidx_s];
`endif

    assign rom_addr      = bus.address;
    assign ram_addr      = bus.address - ADDR_W'(ROM_TOP);
    assign ram_wdata     = bus.data_in;
    assign ram_we        = reset && (state_q == S_IDLE) && bus.req && bus.we && (cur_region_s == REG_RAM);
    assign bus.ready     = ready_q;
    assign bus.err       = err_q;
    assign bus.data_out  = ((state_q == S_MEM) && !we_q) ? mem_rdata_s : dout_q;

    // Next-state, completion staging and port register updates.
    always_comb begin
        state_d    = state_q;
        region_d   = region_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;
        dout_d     = dout_q;
        port_out_d = port_out_q;
        io_fire_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    addr_d   = bus.address;
                    we_d     = bus.we;
                    wdata_d  = bus.data_in;
                    region_d = cur_region_s;
                    case (cur_region_s)
                        REG_ROM, REG_RAM: begin
                            state_d = S_MEM;
                            ready_d = 1'b1;
                            err_d   = (cur_region_s == REG_ROM) && bus.we;
                        end
                        REG_IO: begin
                            if (IO_WAIT == 0) begin
                                state_d   = S_DONE;
                                ready_d   = 1'b1;
                                io_fire_s = 1'b1;
                            end else begin
                                state_d = S_IO;
                                cnt_d   = CW'(IO_WAIT);
                            end
                        end
                        default: begin
                            state_d = S_DONE;
                            ready_d = 1'b1;
                            err_d   = 1'b1;
                            if (!bus.we) begin
                                dout_d = {DATA_W{1'b0}};
                            end else begin
                                dout_d = dout_q;
                            end
                        end
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM: begin
                state_d = S_IDLE;
                if (!we_q) begin
                    dout_d = mem_rdata_s;
                end else begin
                    dout_d = dout_q;
                end
            end
            S_IO: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == CW'(0)) begin
                    state_d   = S_DONE;
                    ready_d   = 1'b1;
                    io_fire_s = 1'b1;
                end else begin
                    state_d = S_IO;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (io_fire_s) begin
            if (cur_we_s) begin
                port_out_d[pidx_s] = cur_wdata_s;
            end else begin
                dout_d = port_rd_s;
            end
        end else begin
            port_out_d = port_out_q;
        end
    end

    // State, staged outputs, port registers and input synchronisers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            region_q <= REG_ROM;
            cnt_q    <= {CW{1'b0}};
            addr_q   <= {ADDR_W{1'b0}};
            we_q     <= 1'b0;
            wdata_q  <= {DATA_W{1'b0}};
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            dout_q   <= {DATA_W{1'b0}};
            for (int k = 0; k < NUM_PORTS; k++) begin
                port_out_q[k] <= {DATA_W{1'b0}};
                sync1_q[k]    <= {DATA_W{1'b0}};
                sync2_q[k]    <= {DATA_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            region_q   <= region_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            port_out_q <= port_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync1_q;
        end
    end
endmodule

// File: tb/tb_mem_map_ctrl.sv
// Directed bench for mem_map_ctrl with behavioural ROM/RAM macros (default parameters).
module tb_mem_map_ctrl;
    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rom_addr, rom_data, ram_addr, ram_wdata, ram_data;
    logic          ram_we;
    logic [127:0]  port_in, port_out;
    logic [7:0]    ram_mem [256];
    int            vectors = 0;
    int            miscompares = 0;
    int            lat;
    logic          s_we;
    logic [7:0]    s_addr, s_wdata;
    logic [127:0]  exp_ports;
    logic [7:0]    hist;
    logic [7:0]    exp_rd;

    mem_map_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    mem_map_ctrl #(
        .ADDR_W(8), .DATA_W(8), .ROM_TOP('h80), .RAM_TOP('hE0),
        .IO_BASE('hF0), .NUM_PORTS(16), .IO_WAIT(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_data  (ram_data),
        .port_in   (port_in),
        .port_out  (port_out)
    );

    always #5 clk = ~clk;

    // ROM contents are addr ^ 'h2C; RAM is a plain synchronous array.
    always @(posedge clk) begin
        rom_data <= rom_addr ^ 8'h2C;
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        ram_data <= ram_mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d);
        bus.req = 1'b1; bus.we = w; bus.address = a; bus.data_in = d;
        #1;
        s_we = ram_we; s_addr = ram_addr; s_wdata = ram_wdata;
        lat = 0;
        do begin
            tick();
            lat++;
            bus.req = 1'b0;
        end while (bus.ready !== 1'b1 && lat < 20);
    endtask

    initial begin
        reset = 1'b0;
        bus.req = 1'b0; bus.we = 1'b0; bus.address = 8'h00; bus.data_in = 8'h00;
        port_in = {16{8'hA5}};
        repeat (3) tick();
        chk("rst_ready", 128'(bus.ready), 128'(1'b0));
        chk("rst_err", 128'(bus.err), 128'(1'b0));
        chk("rst_dout", 128'(bus.data_out), 128'(8'h00));
        chk("rst_ports", port_out, 128'd0);
        reset = 1'b1;
        repeat (3) tick();

`ifdef MEM_MAP_IO_READBACK_EN
        exp_rd = 8'h00;
`else
        exp_rd = 8'hA5;
`endif
        access(1'b0, 8'hF3, 8'h00);
        chk("io_rd_lat", 128'(lat), 128'(3));
        chk("io_rd_data", 128'(bus.data_out), 128'(exp_rd));
        chk("io_rd_err", 128'(bus.err), 128'(1'b0));
        tick();

        access(1'b0, 8'h10, 8'h00);
        chk("rom_rd_lat", 128'(lat), 128'(1));
        chk("rom_rd_data", 128'(bus.data_out), 128'(8'h3C));
        chk("rom_rd_err", 128'(bus.err), 128'(1'b0));
        tick();
        chk("ready_single", 128'(bus.ready), 128'(1'b0));

        access(1'b1, 8'h90, 8'h55);
        chk("ram_wr_we", 128'(s_we), 128'(1'b1));
        chk("ram_wr_addr", 128'(s_addr), 128'(8'h10));
        chk("ram_wr_wdata", 128'(s_wdata), 128'(8'h55));
        chk("ram_wr_lat", 128'(lat), 128'(1));
        chk("ram_wr_err", 128'(bus.err), 128'(1'b0));
        tick();
        access(1'b0, 8'h90, 8'h00);
        chk("ram_rd_data", 128'(bus.data_out), 128'(8'h55));
        tick();

        access(1'b1, 8'hF5, 8'h7E);
        exp_ports = 128'd0;
        exp_ports[47:40] = 8'h7E;
        chk("io_wr_lat", 128'(lat), 128'(3));
        chk("io_wr_ports", port_out, exp_ports);
        tick();

        access(1'b0, 8'hE8, 8'h00);
        chk("gap_lat", 128'(lat), 128'(1));
        chk("gap_err", 128'(bus.err), 128'(1'b1));
        chk("gap_dout", 128'(bus.data_out), 128'(8'h00));
        chk("gap_ramwe", 128'(s_we), 128'(1'b0));
        tick();
        access(1'b1, 8'h05, 8'hAA);
        chk("romwr_lat", 128'(lat), 128'(1));
        chk("romwr_err", 128'(bus.err), 128'(1'b1));
        chk("romwr_ramwe", 128'(s_we), 128'(1'b0));
        chk("romwr_ports", port_out, exp_ports);
        tick();
        chk("err_clears", 128'(bus.err), 128'(1'b0));

        bus.req = 1'b1; bus.we = 1'b1; bus.address = 8'hF2; bus.data_in = 8'h99;
        tick();
        bus.req = 1'b0;
        chk("abort_wait1", 128'(bus.ready), 128'(1'b0));
        reset = 1'b0;
        tick();
        chk("abort_ready", 128'(bus.ready), 128'(1'b0));
        tick();
        reset = 1'b1;
        tick();
        chk("abort_ready2", 128'(bus.ready), 128'(1'b0));
        tick();
        chk("abort_ready3", 128'(bus.ready), 128'(1'b0));
        chk("abort_ports", port_out, 128'd0);
        access(1'b0, 8'h20, 8'h00);
        chk("post_rst_lat", 128'(lat), 128'(1));
        chk("post_rst_data", 128'(bus.data_out), 128'(8'h0C));
        tick();

        hist = 8'h00;
        bus.req = 1'b1; bus.we = 1'b0; bus.address = 8'h90;
        for (int i = 0; i < 8; i++) begin
            tick();
            hist = {bus.ready, hist[7:1]};
        end
        bus.req = 1'b0;
        chk("b2b_pattern", 128'(hist), 128'(8'h55));
        chk("b2b_data", 128'(bus.data_out), 128'(8'h55));
        tick();

`ifdef MEM_MAP_IO_READBACK_EN
        exp_rd = 8'h11;
`else
        exp_rd = 8'hA5;
`endif
        access(1'b1, 8'hF0, 8'h11);
        chk("p0_wr_lat", 128'(lat), 128'(3));
        chk("p0_wr_ports", port_out, 128'(8'h11));
        tick();
        access(1'b0, 8'hF0, 8'h00);
        chk("p0_rd_data", 128'(bus.data_out), 128'(exp_rd));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
